// File: rtl/shift_unit_mc_if.sv
//==========================================================================
// shift_unit_mc_if : request/result bundle for the multi-cycle shifter
// Revision 1.0 - initial release
//==========================================================================
`default_nettype none

interface shift_unit_mc_if #(
  parameter int WIDTH = 16
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_zero;
  logic               out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );
endinterface

`default_nettype wire

// File: rtl/shift_unit_mc.sv
//==========================================================================
// shift_unit_mc : multi-cycle barrel shifter, one shamt bit per cycle.
// Optional rotate right enabled by macro SHIFT_ROR_EN. Revision 1.0
//==========================================================================
`default_nettype none

module shift_unit_mc #(
  parameter int WIDTH = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  shift_unit_mc_if.slave bus,
  output logic           busy
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   work_q,  work_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [SHAMT_W-1:0] k_q,     k_d;
  logic [1:0]         mode_q,  mode_d;
  logic               zero_q,  zero_d;
  logic               err_q,   err_d;

  logic               w_accept;
  logic               w_bypass;
  logic               w_acc_err;
  logic [SHAMT_W-1:0] w_amt;
  logic [WIDTH-1:0]   w_shifted;
  logic [WIDTH-1:0]   w_step;
  logic               w_last;

  assign w_accept = bus.in_valid && (state_q == S_IDLE);

`ifdef SHIFT_ROR_EN
  assign w_bypass  = (bus.in_shamt == '0);
  assign w_acc_err = 1'b0;
`else
  // Without rotate support mode 11 completes like a zero shift and flags an error.
  assign w_bypass  = (bus.in_shamt == '0) || (bus.in_mode == 2'b11);
  assign w_acc_err = (bus.in_mode == 2'b11);
`endif

  // Stage k moves the operand by 2^k; the largest stage is WIDTH/2.
  assign w_amt = SHAMT_W'(1) << k_q;

  always_comb begin
    w_shifted = work_q;
    case (mode_q)
      2'b00:   w_shifted = work_q << w_amt;
      2'b01:   w_shifted = work_q >> w_amt;
      2'b10:   w_shifted = $signed(work_q) >>> w_amt;
      default: begin
`ifdef SHIFT_ROR_EN
        w_shifted = (work_q >> w_amt) | (work_q << (WIDTH - int'(w_amt)));
`else
        w_shifted = work_q;
`endif
      end
    endcase
  end

  assign w_step = shamt_q[k_q] ? w_shifted : work_q;
  // Stop as soon as no higher shamt bit remains set.
  assign w_last = (k_q == SHAMT_W'(SHAMT_W - 1)) || (((shamt_q >> k_q) >> 1) == '0);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    k_d     = k_q;
    mode_d  = mode_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          work_d  = bus.in_data;
          shamt_d = bus.in_shamt;
          mode_d  = bus.in_mode;
          k_d     = '0;
          if (w_bypass) begin
            state_d = S_DONE;
            zero_d  = (bus.in_data == '0);
            err_d   = w_acc_err;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = w_step;
        if (w_last) begin
          state_d = S_DONE;
          zero_d  = (w_step == '0);
          err_d   = 1'b0;
        end else begin
          k_d = k_q + SHAMT_W'(1);
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
          zero_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        zero_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      shamt_q <= '0;
      k_q     <= '0;
      mode_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
      k_q     <= k_d;
      mode_q  <= mode_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_data  = work_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_err   = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shift_unit_mc.sv
//==========================================================================
// tb_shift_unit_mc : vector table, corner sequences and random model check
// Revision 1.0
//==========================================================================
`default_nettype none

module tb_shift_unit_mc;
  localparam int WIDTH = 16;
`ifdef SHIFT_ROR_EN
  localparam bit ROR = 1'b1;
`else
  localparam bit ROR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_unit_mc_if #(.WIDTH(WIDTH)) bus ();

  shift_unit_mc #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  s;
    logic [1:0]  m;
    logic [15:0] ed;
    logic        ez;
    logic        ee;
    int          el;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Whole-operand reference: shift the full amount in one step.
  function automatic void model(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m,
                                output logic [15:0] r, output logic e, output int lat);
    logic signed [15:0] sd;
    logic [31:0]        dd;
    int                 msb;
    sd  = d;
    dd  = {d, d};
    e   = 1'b0;
    msb = 0;
    for (int i = 0; i < 4; i++) if (s[i]) msb = i;
    lat = (s == 4'd0) ? 1 : msb + 2;
    case (m)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = sd >>> s;
      default: begin
        if (ROR) begin
          dd = dd >> s;
          r  = dd[15:0];
        end else begin
          r   = d;
          e   = 1'b1;
          lat = 1;
        end
      end
    endcase
  endfunction

  // Present a request once idle; latency counts edges until out_valid is seen.
  task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m, output int lat);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_mode  = m;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
        bus.in_shamt = 4'($urandom);
        bus.in_mode  = 2'($urandom);
      end
    end while (!bus.out_valid && lat < 20);
  endtask

  task automatic finish_req(input bit rnd);
    logic [15:0] held;
    int  n = 0;
    bit  done = 1'b0;
    held = bus.out_data;
    while (!done && n < 64) begin
      bus.out_ready = (rnd && n < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      n++;
      if (bus.out_ready) done = 1'b1;
      else begin
        check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_data", {16'd0, bus.out_data}, {16'd0, held});
      end
    end
    bus.out_ready = 1'b0;
    check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed, input logic ee, input int el, input int lat);
    check({tag, "_lat"}, lat, el);
    check({tag, "_data"}, {16'd0, bus.out_data}, {16'd0, ed});
    check({tag, "_zero"}, {31'd0, bus.out_zero}, {31'd0, (ed == 16'd0)});
    check({tag, "_err"}, {31'd0, bus.out_err}, {31'd0, ee});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [15:0] r;
    logic        e;
    int          el;
    bit          saw;

    tbl.push_back('{16'h8000, 4'd3,  2'b10, 16'hF000, 1'b0, 1'b0, 3});
    tbl.push_back('{16'h7FF0, 4'd4,  2'b10, 16'h07FF, 1'b0, 1'b0, 4});
    tbl.push_back('{16'h8001, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0, 5});
    tbl.push_back('{16'h0001, 4'd15, 2'b00, 16'h8000, 1'b0, 1'b0, 5});
    tbl.push_back('{16'h8000, 4'd15, 2'b01, 16'h0001, 1'b0, 1'b0, 5});
    tbl.push_back('{16'h00FF, 4'd8,  2'b00, 16'hFF00, 1'b0, 1'b0, 5});
    tbl.push_back('{16'h0001, 4'd1,  2'b01, 16'h0000, 1'b1, 1'b0, 2});
    tbl.push_back('{16'h0000, 4'd5,  2'b01, 16'h0000, 1'b1, 1'b0, 4});
    tbl.push_back('{16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0, 1'b0, 1});
    if (ROR) begin
      tbl.push_back('{16'h0001, 4'd1, 2'b11, 16'h8000, 1'b0, 1'b0, 2});
      tbl.push_back('{16'hF00F, 4'd4, 2'b11, 16'hFF00, 1'b0, 1'b0, 4});
    end else begin
      tbl.push_back('{16'h0001, 4'd1, 2'b11, 16'h0001, 1'b0, 1'b1, 1});
      tbl.push_back('{16'hF00F, 4'd4, 2'b11, 16'hF00F, 1'b0, 1'b1, 1});
    end

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
    check("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].s, tbl[i].m, lat);
      check_result($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ee, tbl[i].el, lat);
      check($sformatf("vec%0d_zero_tbl", i), {31'd0, bus.out_zero}, {31'd0, tbl[i].ez});
      finish_req(1'b0);
    end

    // Backpressure: result holds, new requests ignored, DONE never accepts.
    send(16'h1234, 4'd0, 2'b00, lat);
    check_result("bp", 16'h1234, 1'b0, 1, lat);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hBEEF;
    bus.in_shamt = 4'd3;
    bus.in_mode  = 2'b00;
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_data", {16'd0, bus.out_data}, 32'h1234);
      check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_rel_valid", {31'd0, bus.out_valid}, 32'd0);
    check("bp_rel_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    check("bp_no_capture_busy", {31'd0, busy}, 32'd0);
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw = 1'b1;
    end
    check("bp_no_extra_result", {31'd0, saw}, 32'd0);

    // Asynchronous reset in the middle of a shift.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    bus.in_shamt = 4'd15;
    bus.in_mode  = 2'b00;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_data", {16'd0, bus.out_data}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid || busy) saw = 1'b1;
    end
    check("mid_rst_no_result", {31'd0, saw}, 32'd0);

    // Random back-to-back traffic with random backpressure.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] d;
      logic [3:0]  s;
      logic [1:0]  m;
      d = 16'($urandom);
      s = 4'($urandom);
      m = 2'($urandom);
      if ($urandom_range(0, 7) == 0) d = 16'd0;
      model(d, s, m, r, e, el);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      send(d, s, m, lat);
      check_result("rnd", r, e, el, lat);
      finish_req(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_unit_mc.md
# shift_unit_mc

Multi-cycle, parametrised barrel shifter for the execute stage, replacing the fixed 16-bit arithmetic-right shifter. Supports logical left, logical right, arithmetic right and (optionally) rotate right on a WIDTH-bit operand. The shift is resolved one shift-amount bit per cycle under a valid/ready handshake, so it can stall the pipeline instead of adding a long combinational path. It sits between the register-read operand muxes and the writeback mux.

## Interface
- WIDTH, 16, operand width; power of two, ≥ 4.
- SHAMT_W (localparam), log2(WIDTH), shift-amount width; not overridable.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, unsigned, 0..WIDTH-1.
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_err  out  1  request used a mode not compiled in.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). Accept = in_valid & in_ready; on accept, latch in_data into the working register, and latch in_shamt, in_mode and k = 0.
- IDLE → DONE on accept with in_shamt == 0; working register unchanged.
- IDLE → SHIFT on accept with in_shamt != 0.
- SHIFT, each cycle: if shamt[k] = 1, shift the working register by 2^k per mode, else hold.
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with bit WIDTH-1 of the current working value.
  - ROR: bits leaving the LSB enter the MSB.
- Early exit: after processing bit k, go to DONE if k == SHAMT_W-1 or shamt[SHAMT_W-1:k+1] == 0; otherwise k ← k+1.
- DONE: out_valid = 1; out_data, out_zero and out_err are stable. DONE → IDLE when out_ready = 1.
- Changes to in_data, in_shamt and in_mode after accept have no effect.
- in_valid while busy is ignored, and the request is not captured.
- out_zero and out_err are held at 0 whenever out_valid = 0.

## Timing
- Reset (async assert, any state): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_zero = 0, out_err = 0, busy = 0, working registers = 0. An in-flight request is discarded with no output.
- Latency, from accept edge N to the edge where out_valid rises:
  - shamt == 0: 1 cycle.
  - otherwise: msb_index(shamt) + 2 cycles.
  - Maximum: SHAMT_W + 1 cycles (5 for WIDTH = 16).
- Handshake completes on the edge with out_valid & out_ready; in_ready rises the following cycle.
- The earliest next accept is 1 cycle after the result handshake. DONE never accepts a new request, even when out_ready = 1.
- out_ready held low: DONE persists indefinitely with outputs unchanged.
- All outputs are registered or decoded from state. No combinational path from in_* or out_ready to any output.

## Configuration
- SHIFT_ROR_EN defined: mode 11 performs rotate right; out_err is always 0.
- SHIFT_ROR_EN undefined: mode 11 returns in_data unchanged with out_err = 1; latency is the same as shamt == 0 (1 cycle), and no rotate logic is synthesised.

## Test plan
- Reset/idle: assert rst_n = 0 mid-SHIFT → in_ready = 1, out_valid = 0, out_data = 0 immediately; no result appears after release.
- SRA, WIDTH = 16: in_data 0x8000, shamt 3, mode 10 → out_data 0xF000 with out_valid at N+3. Also 0x7FF0, shamt 4 → 0x07FF.
- SLL/SRL extremes: 0x0001, shamt 15, SLL → 0x8000 at N+5. 0x8000, shamt 15, SRL → 0x0001. 0x00FF, shamt 8, SLL → 0xFF00, out_zero = 0. 0x0001, shamt 1, SRL → 0x0000, out_zero = 1.
- shamt 0 and backpressure: 0x1234, shamt 0 → 0x1234 at N+1. Hold out_ready = 0 for 10 cycles → outputs stable, in_ready = 0, a new in_valid is ignored. Release → in_ready = 1 the next cycle.
- ROR: 0x0001, shamt 1 → 0x8000 with SHIFT_ROR_EN. Without it → 0x0001, out_err = 1, latency 1.
- Back-to-back random: 1000 requests with random mode/shamt/data and random out_ready, checked against a reference model for data and latency.
